// File: rtl/register_file.sv
// Eight-entry register storage behind the ALU: R1-R4 and S1-S4 with per-register
// in-place functions on write and two independent combinational read ports.
module register_file #(
  parameter int WIDTH = 32
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] I,
  input  logic [2:0]       FunSel,
  input  logic [3:0]       RegSel,
  input  logic [3:0]       ScrSel,
  input  logic [2:0]       OutASel,
  input  logic [2:0]       OutBSel,
  output logic [WIDTH-1:0] OutA,
  output logic [WIDTH-1:0] OutB
);

  typedef enum logic [2:0] {
    FUN_DEC         = 3'b000,
    FUN_INC         = 3'b001,
    FUN_LOAD        = 3'b010,
    FUN_CLEAR       = 3'b011,
    FUN_CLEAR_LOAD8 = 3'b100,
    FUN_LOAD8       = 3'b101,
    FUN_LOAD16      = 3'b110,
    FUN_SHIFT_IN8   = 3'b111
  } fun_e;

  localparam int NUM_REGS = 8;

  // Entries 0-3 are R1-R4, entries 4-7 are S1-S4, matching the read-select encoding.
  logic [WIDTH-1:0] regs_q [NUM_REGS];
  logic [WIDTH-1:0] regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] write_en;
  fun_e fun;

  assign write_en = {ScrSel, RegSel};
  assign fun      = fun_e'(FunSel);

  function automatic logic [WIDTH-1:0] apply_fun(
    input fun_e             f,
    input logic [WIDTH-1:0] q,
    input logic [WIDTH-1:0] d
  );
    logic [WIDTH-1:0] r;
    r = q;
    case (f)
      FUN_DEC:         r = q - WIDTH'(1);
      FUN_INC:         r = q + WIDTH'(1);
      FUN_LOAD:        r = d;
      FUN_CLEAR:       r = '0;
      FUN_CLEAR_LOAD8: r = {{(WIDTH-8){1'b0}}, d[7:0]};
      FUN_LOAD8:       r = {q[WIDTH-1:8], d[7:0]};
      FUN_LOAD16:      r = {q[WIDTH-1:16], d[15:0]};
      FUN_SHIFT_IN8:   r = {q[WIDTH-9:0], d[7:0]};
      default:         r = q;
    endcase
    return r;
  endfunction

  // NOTE: every regs_d entry gets its hold value first so no path leaves it unassigned (no latch).
  always_comb begin
    for (int k = 0; k < NUM_REGS; k++) begin
      regs_d[k] = regs_q[k];
      if (write_en[k]) begin
        regs_d[k] = apply_fun(fun, regs_q[k], I);
      end
    end
  end

  // NOTE: these eight words are individual flops, not a RAM macro, so resetting them is intended.
  // NOTE: non-blocking assignments here so every register samples pre-edge values together.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        regs_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_REGS; k++) begin
        regs_q[k] <= regs_d[k];
      end
    end
  end

  // Reads see current contents only; a same-cycle write appears after the edge.
  assign OutA = regs_q[OutASel];
  assign OutB = regs_q[OutBSel];

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: a reference model pushes expected
// register contents to a scoreboard queue that each scenario drains through the read ports.
module tb_register_file;

  localparam int WIDTH = 32;

  logic             Clock;
  logic             Reset;
  logic [WIDTH-1:0] I;
  logic [2:0]       FunSel;
  logic [3:0]       RegSel;
  logic [3:0]       ScrSel;
  logic [2:0]       OutASel;
  logic [2:0]       OutBSel;
  logic [WIDTH-1:0] OutA;
  logic [WIDTH-1:0] OutB;

  typedef struct {
    string            tag;
    int               idx;
    logic [WIDTH-1:0] val;
  } exp_t;

  exp_t             sb[$];
  logic [WIDTH-1:0] model [8];
  int               n_checks = 0;
  int               n_fail   = 0;

  register_file #(.WIDTH(WIDTH)) dut (
    .Clock  (Clock),
    .Reset  (Reset),
    .I      (I),
    .FunSel (FunSel),
    .RegSel (RegSel),
    .ScrSel (ScrSel),
    .OutASel(OutASel),
    .OutBSel(OutBSel),
    .OutA   (OutA),
    .OutB   (OutB)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog");
  end

  function automatic logic [WIDTH-1:0] model_next(input logic [2:0] f,
                                                  input logic [WIDTH-1:0] q,
                                                  input logic [WIDTH-1:0] d);
    case (f)
      3'd0:    return q - 32'd1;
      3'd1:    return q + 32'd1;
      3'd2:    return d;
      3'd3:    return 32'd0;
      3'd4:    return d & 32'h0000_00FF;
      3'd5:    return (q & 32'hFFFF_FF00) | (d & 32'h0000_00FF);
      3'd6:    return (q & 32'hFFFF_0000) | (d & 32'h0000_FFFF);
      default: return (q << 8) | (d & 32'h0000_00FF);
    endcase
  endfunction

  // Drive one write cycle, advance the model, then leave enables off.
  task automatic write_cycle(input logic [2:0] f, input logic [3:0] rs,
                             input logic [3:0] ss, input logic [WIDTH-1:0] d);
    logic [7:0] en;
    FunSel = f; RegSel = rs; ScrSel = ss; I = d;
    en = {ss, rs};
    @(posedge Clock);
    #1;
    for (int k = 0; k < 8; k++) if (en[k]) model[k] = model_next(f, model[k], d);
    RegSel = 4'b0000; ScrSel = 4'b0000;
  endtask

  task automatic push_one(input string tag, input int idx, input logic [WIDTH-1:0] v);
    exp_t e;
    e.tag = tag; e.idx = idx; e.val = v;
    sb.push_back(e);
  endtask

  task automatic push_model(input string tag);
    for (int k = 0; k < 8; k++) push_one(tag, k, model[k]);
  endtask

  task automatic test_reset;
    exp_t e;
    Reset = 1'b1; I = '0; FunSel = 3'd0; RegSel = '0; ScrSel = '0;
    OutASel = '0; OutBSel = '0;
    repeat (2) @(posedge Clock);
    #1;
    Reset = 1'b0;
    for (int k = 0; k < 8; k++) model[k] = '0;
    for (int k = 0; k < 8; k++) begin
      OutASel = 3'(k); OutBSel = 3'(7 - k);
      #1;
      n_checks++;
      if (OutA !== 32'h0) begin n_fail++; $display("FAIL reset_sweep_A sel=%0d got=%h exp=00000000", k, OutA); end
      n_checks++;
      if (OutB !== 32'h0) begin n_fail++; $display("FAIL reset_sweep_B sel=%0d got=%h exp=00000000", 7 - k, OutB); end
    end
    // Fill everything, then assert Reset mid-cycle while a full LOAD is pending.
    write_cycle(3'b010, 4'b1111, 4'b1111, 32'hA5A5_A5A5);
    FunSel = 3'b010; RegSel = 4'b1111; ScrSel = 4'b1111; I = 32'h5A5A_5A5A;
    OutASel = 3'd0; OutBSel = 3'd7;
    #3;
    Reset = 1'b1;
    #1;
    n_checks++;
    if (OutA !== 32'h0) begin n_fail++; $display("FAIL reset_async got=%h exp=00000000", OutA); end
    @(posedge Clock);
    #1;
    for (int k = 0; k < 8; k++) model[k] = '0;
    push_model("reset_over_load");
    Reset = 1'b0; RegSel = '0; ScrSel = '0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      OutASel = 3'(e.idx); OutBSel = 3'(e.idx);
      #1;
      n_checks++;
      if (OutA !== e.val) begin n_fail++; $display("FAIL %s A reg=%0d got=%h exp=%h", e.tag, e.idx, OutA, e.val); end
      n_checks++;
      if (OutB !== e.val) begin n_fail++; $display("FAIL %s B reg=%0d got=%h exp=%h", e.tag, e.idx, OutB, e.val); end
    end
  endtask

  task automatic test_load_dual_read;
    exp_t e;
    write_cycle(3'b010, 4'b0001, 4'b0000, 32'hDEAD_BEEF);
    write_cycle(3'b010, 4'b0000, 4'b1000, 32'h1234_5678);
    push_one("load_r1", 0, 32'hDEAD_BEEF);
    push_one("load_s4", 7, 32'h1234_5678);
    push_model("load_all");
    OutASel = 3'b000; OutBSel = 3'b111;
    #1;
    n_checks++;
    if (OutA !== 32'hDEAD_BEEF || OutB !== 32'h1234_5678) begin
      n_fail++; $display("FAIL dual_read A=%h B=%h exp A=deadbeef B=12345678", OutA, OutB);
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      OutASel = 3'(e.idx); OutBSel = 3'(e.idx);
      #1;
      n_checks++;
      if (OutA !== e.val) begin n_fail++; $display("FAIL %s A reg=%0d got=%h exp=%h", e.tag, e.idx, OutA, e.val); end
      n_checks++;
      if (OutB !== e.val) begin n_fail++; $display("FAIL %s B reg=%0d got=%h exp=%h", e.tag, e.idx, OutB, e.val); end
    end
  endtask

  task automatic test_wrap;
    exp_t e;
    write_cycle(3'b011, 4'b0010, 4'b0000, 32'hFFFF_0000);
    write_cycle(3'b000, 4'b0010, 4'b0000, 32'h0);
    push_one("wrap_dec", 1, 32'hFFFF_FFFF);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      OutASel = 3'(e.idx); OutBSel = 3'(e.idx);
      #1;
      n_checks++;
      if (OutA !== e.val) begin n_fail++; $display("FAIL %s reg=%0d got=%h exp=%h", e.tag, e.idx, OutA, e.val); end
    end
    write_cycle(3'b001, 4'b0010, 4'b0000, 32'h0);
    push_one("wrap_inc", 1, 32'h0000_0000);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      OutASel = 3'(e.idx); OutBSel = 3'(e.idx);
      #1;
      n_checks++;
      if (OutA !== e.val) begin n_fail++; $display("FAIL %s reg=%0d got=%h exp=%h", e.tag, e.idx, OutA, e.val); end
    end
    write_cycle(3'b001, 4'b0010, 4'b0000, 32'h0);
    write_cycle(3'b001, 4'b0010, 4'b0000, 32'h0);
    push_one("inc_twice", 1, 32'h0000_0002);
    push_model("wrap_all");
    while (sb.size() > 0) begin
      e = sb.pop_front();
      OutASel = 3'(e.idx); OutBSel = 3'(e.idx);
      #1;
      n_checks++;
      if (OutA !== e.val) begin n_fail++; $display("FAIL %s reg=%0d got=%h exp=%h", e.tag, e.idx, OutA, e.val); end
    end
  endtask

  task automatic test_partial;
    exp_t e;
    logic [2:0]       funs [4];
    logic [WIDTH-1:0] ins  [4];
    logic [WIDTH-1:0] outs [4];
    funs = '{3'b101, 3'b110, 3'b111, 3'b100};
    ins  = '{32'h0000_0011, 32'h0000_9876, 32'h0000_00EE, 32'h1234_5655};
    outs = '{32'hAABB_CC11, 32'hAABB_9876, 32'hBB98_76EE, 32'h0000_0055};
    write_cycle(3'b010, 4'b0100, 4'b0000, 32'hAABB_CCDD);
    for (int s = 0; s < 4; s++) begin
      write_cycle(funs[s], 4'b0100, 4'b0000, ins[s]);
      push_one($sformatf("partial_fun%0d", funs[s]), 2, outs[s]);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        OutASel = 3'(e.idx); OutBSel = 3'(e.idx);
        #1;
        n_checks++;
        if (OutA !== e.val) begin n_fail++; $display("FAIL %s reg=%0d got=%h exp=%h", e.tag, e.idx, OutA, e.val); end
      end
    end
  endtask

  task automatic test_multi_enable;
    exp_t e;
    write_cycle(3'b011, 4'b1111, 4'b1111, 32'h0);
    write_cycle(3'b010, 4'b0001, 4'b0000, 32'd5);
    write_cycle(3'b010, 4'b1000, 4'b0000, 32'd9);
    write_cycle(3'b010, 4'b0000, 4'b0010, 32'h100);
    write_cycle(3'b001, 4'b1001, 4'b0010, 32'hFFFF_FFFF);
    push_one("multi_r1", 0, 32'd6);
    push_one("multi_r4", 3, 32'd10);
    push_one("multi_s2", 5, 32'h101);
    push_model("multi_all");
    write_cycle(3'b011, 4'b0000, 4'b0000, 32'hFFFF_FFFF);
    push_model("no_enable_hold");
    while (sb.size() > 0) begin
      e = sb.pop_front();
      OutASel = 3'(e.idx); OutBSel = 3'(e.idx);
      #1;
      n_checks++;
      if (OutA !== e.val) begin n_fail++; $display("FAIL %s A reg=%0d got=%h exp=%h", e.tag, e.idx, OutA, e.val); end
      n_checks++;
      if (OutB !== e.val) begin n_fail++; $display("FAIL %s B reg=%0d got=%h exp=%h", e.tag, e.idx, OutB, e.val); end
    end
  endtask

  task automatic test_read_during_write;
    write_cycle(3'b010, 4'b0010, 4'b0000, 32'h10);
    OutASel = 3'b001; OutBSel = 3'b001;
    FunSel = 3'b010; RegSel = 4'b0010; ScrSel = 4'b0000; I = 32'h20;
    @(negedge Clock);
    n_checks++;
    if (OutA !== 32'h10) begin n_fail++; $display("FAIL rdw_before A got=%h exp=00000010", OutA); end
    n_checks++;
    if (OutB !== OutA) begin n_fail++; $display("FAIL rdw_before B got=%h exp=%h", OutB, OutA); end
    @(posedge Clock);
    #1;
    RegSel = 4'b0000;
    model[1] = 32'h20;
    n_checks++;
    if (OutA !== 32'h20) begin n_fail++; $display("FAIL rdw_after A got=%h exp=00000020", OutA); end
    n_checks++;
    if (OutB !== 32'h20) begin n_fail++; $display("FAIL rdw_after B got=%h exp=00000020", OutB); end
    @(negedge Clock);
    n_checks++;
    if (OutA !== 32'h20 || OutB !== 32'h20) begin
      n_fail++; $display("FAIL rdw_hold A=%h B=%h exp=00000020", OutA, OutB);
    end
  endtask

  initial begin
    test_reset();
    test_load_dual_read();
    test_wrap();
    test_partial();
    test_multi_enable();
    test_read_during_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- Eight-entry, 32-bit register storage stage directly downstream of the ALU.
- Captures the ALU result, or any other word on its data input, into general-purpose registers R1-R4 and scratch registers S1-S4.
- Each register supports per-register in-place functions: increment, decrement, clear and partial loads.
- Provides two independent read ports, OutA and OutB, which drive the ALU A and B operand inputs.

Parameters:
WIDTH, 32, data width of every register and of I/OutA/OutB; must be at least 16

Ports:
Clock  input  1  system clock; all register updates on rising edge
Reset  input  1  asynchronous, active-high; clears all eight registers
I  input  WIDTH  write data (ALUOut or memory/immediate mux output)
FunSel  input  3  function applied to every enabled register
RegSel  input  4  per-register enables for R1-R4; bit0=R1, bit1=R2, bit2=R3, bit3=R4; 1=enabled
ScrSel  input  4  per-register enables for S1-S4; bit0=S1 ... bit3=S4; 1=enabled
OutASel  input  3  read select A: 000-011 = R1-R4, 100-111 = S1-S4
OutBSel  input  3  read select B: same encoding as OutASel
OutA  output  WIDTH  contents of register selected by OutASel
OutB  output  WIDTH  contents of register selected by OutBSel

Behaviour:
- Reset asserted, at any time, asynchronously:
  - All eight registers go to 0.
  - Reset dominates any concurrent write, including one on the same edge.
  - OutA and OutB therefore read 0 for every select value while Reset is high and until the first write after release.
- Write path: at each rising Clock edge, every register whose enable bit is 1 is updated per FunSel. Registers with enable 0 hold.
- FunSel encoding, Q = current value, Q' = next value:
  - 000: Q' = Q - 1, modulo 2^WIDTH; 0 wraps to all-ones.
  - 001: Q' = Q + 1, modulo 2^WIDTH; all-ones wraps to 0.
  - 010: Q' = I (full load).
  - 011: Q' = 0 (clear).
  - 100: Q'[WIDTH-1:8] = 0, Q'[7:0] = I[7:0] (clear, then write low byte).
  - 101: Q'[7:0] = I[7:0]; upper bits hold.
  - 110: Q'[15:0] = I[15:0]; upper bits hold.
  - 111: Q' = {Q[WIDTH-9:0], I[7:0]} (shift left 8, insert low byte).
- Multiple enables: any combination of the eight enables may be active in the same cycle.
  - Each enabled register applies FunSel to its own current value.
  - Example: INC with RegSel=1111 increments all four R registers independently.
- No carry or overflow outputs; wrap-around is silent. Flags are the ALU's responsibility.
- Read path:
  - OutA and OutB are combinational muxes of the current register contents. No read latency.
  - OutASel and OutBSel may select the same register; both ports then show the same value.
- Read-during-write: a port reading a register being written shows the pre-edge value until the rising edge and the new value immediately after it. There is no write-through bypass.
- All-zero enables: no state change regardless of FunSel or I.
- Unknown/X on FunSel with any enable active is illegal. The bench must not drive it.

Test Plan:
- Reset then read: pulse Reset for 2 cycles; sweep OutASel/OutBSel over 000-111 -> all 16 reads return 0x00000000. Assert Reset mid-cycle during a LOAD with RegSel=1111 -> registers stay 0 and the LOAD is lost.
- Load and dual read: I=0xDEADBEEF, FunSel=010, RegSel=0001, one edge; then I=0x12345678, ScrSel=1000, one edge -> OutASel=000 gives 0xDEADBEEF, OutBSel=111 gives 0x12345678, all others 0.
- Wrap-around: R2 cleared (011), then DEC (000) once -> 0xFFFFFFFF; then INC (001) once -> 0x00000000; then INC twice -> 0x00000002.
- Partial writes on R3=0xAABBCCDD:
  - 101 with I=0x00000011 -> 0xAABBCC11.
  - 110 with I=0x00009876 -> 0xAABB9876.
  - 111 with I=0x000000EE -> 0xBB9876EE.
  - 100 with I=0x12345655 -> 0x00000055.
- Multiple enables and hold: R1=5, R4=9, S2=0x100, others 0; FunSel=001, RegSel=1001, ScrSel=0010 -> R1=6, R4=10, S2=0x101, R2/R3/S1/S3/S4 unchanged. Repeat with all enables 0 and FunSel=011 -> no change.
- Read-during-write: OutASel=001 on R2=0x10, LOAD I=0x20 into R2 -> OutA=0x10 up to the edge, 0x20 from the edge onward; OutBSel=001 at the same time -> OutB identical to OutA in every cycle.
